// File: rtl/regfile_alu_datapath_pkg.sv
// Shared widths, register-file constants and ALU function-select encodings
// for the register-file / ALU datapath slice.
package regfile_alu_datapath_pkg;
    localparam int DATA_W = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int SH_W   = 6;
    localparam int NDBG   = 8;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    // FS[4:2] operation codes
    localparam logic [2:0] FS_AND = 3'b000;
    localparam logic [2:0] FS_OR  = 3'b001;
    localparam logic [2:0] FS_ADD = 3'b010;
    localparam logic [2:0] FS_XOR = 3'b011;
    localparam logic [2:0] FS_LSL = 3'b100;
    localparam logic [2:0] FS_LSR = 3'b101;

    // FS bits that invert the A and B operands before the operation
    localparam int INV_A_BIT = 1;
    localparam int INV_B_BIT = 0;
endpackage

// File: rtl/alu64.sv
// 64-bit function-select ALU with optional operand inversion and combinational
// {V, C, N, Z} flags; carry and overflow are only meaningful for ADD.
module alu64
    import regfile_alu_datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        fs,
    input  logic              c0,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        status
);
    logic [DATA_W-1:0] a_mod;
    logic [DATA_W-1:0] b_mod;
    logic [DATA_W:0]   sum;
    logic              carry;
    logic              ovf;

    always_comb begin
        a_mod  = fs[INV_A_BIT] ? ~a : a;
        b_mod  = fs[INV_B_BIT] ? ~b : b;
        sum    = {1'b0, a_mod} + {1'b0, b_mod} + {{DATA_W{1'b0}}, c0};
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (fs[4:2])
            FS_AND: result = a_mod & b_mod;
            FS_OR:  result = a_mod | b_mod;
            FS_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                ovf    = (a_mod[DATA_W-1] == b_mod[DATA_W-1]) &&
                         (sum[DATA_W-1] != a_mod[DATA_W-1]);
            end
            FS_XOR: result = a_mod ^ b_mod;
            // Shifts use the uninverted operands; only B[5:0] is the amount.
            FS_LSL: result = a << b[SH_W-1:0];
            FS_LSR: result = a >> b[SH_W-1:0];
            default: result = '0;
        endcase
    end

    assign status = {ovf, carry, result[DATA_W-1], (result == '0)};
endmodule

// File: rtl/regfile32x64.sv
// 32 x 64 register file: two combinational read ports, one synchronous write
// port, register 31 hard-wired to zero, registers 0..7 exported for debug.
module regfile32x64
    import regfile_alu_datapath_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wa,
    input  logic [DATA_W-1:0]            wd,
    input  logic [ADDR_W-1:0]            ra_a,
    input  logic [ADDR_W-1:0]            ra_b,
    output logic [DATA_W-1:0]            rd_a,
    output logic [DATA_W-1:0]            rd_b,
    output logic [NDBG-1:0][DATA_W-1:0]  dbg
);
    logic [DATA_W-1:0] regs_reg [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (wa != ZERO_REG)) begin
            regs_reg[wa] <= wd;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
    assign rd_a = (ra_a == ZERO_REG) ? '0 : regs_reg[ra_a];
    assign rd_b = (ra_b == ZERO_REG) ? '0 : regs_reg[ra_b];

    generate
        for (genvar gi = 0; gi < NDBG; gi++) begin : g_dbg
            assign dbg[gi] = regs_reg[gi];
        end
    endgenerate
endmodule

// File: rtl/regfile_alu_datapath.sv
// Datapath slice: register file, K/register operand-B mux, ALU, and a muxed
// data bus (ALU result has priority over operand B) feeding write-back.
module regfile_alu_datapath
    import regfile_alu_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              W,
    input  logic [ADDR_W-1:0] DA,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [DATA_W-1:0] K,
    input  logic              K_SEL,
    input  logic [4:0]        FS,
    input  logic              C0,
    input  logic              EN_ALU,
    input  logic              EN_B,
    output logic [3:0]        Status,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7
);
    logic [DATA_W-1:0]            a_data;
    logic [DATA_W-1:0]            b_reg_data;
    logic [DATA_W-1:0]            b_data;
    logic [DATA_W-1:0]            alu_result;
    logic [DATA_W-1:0]            bus_data;
    logic [NDBG-1:0][DATA_W-1:0]  dbg;

    regfile32x64 u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we   (W),
        .wa   (DA),
        .wd   (bus_data),
        .ra_a (SA),
        .ra_b (SB),
        .rd_a (a_data),
        .rd_b (b_reg_data),
        .dbg  (dbg)
    );

    assign b_data = K_SEL ? K : b_reg_data;

    alu64 u_alu (
        .a      (a_data),
        .b      (b_data),
        .fs     (FS),
        .c0     (C0),
        .result (alu_result),
        .status (Status)
    );

    always_comb begin
        bus_data = '0;
        if (EN_ALU) begin
            bus_data = alu_result;
        end else if (EN_B) begin
            bus_data = b_data;
        end
    end

    assign r0 = dbg[0];
    assign r1 = dbg[1];
    assign r2 = dbg[2];
    assign r3 = dbg[3];
    assign r4 = dbg[4];
    assign r5 = dbg[5];
    assign r6 = dbg[6];
    assign r7 = dbg[7];
endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Scoreboard bench for regfile_alu_datapath: expected write-backs are queued
// when an operation is driven and compared against r0..r7 after the edge.
module tb_regfile_alu_datapath;
    logic        clk;
    logic        rst;
    logic        W;
    logic [4:0]  DA;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [63:0] K;
    logic        K_SEL;
    logic [4:0]  FS;
    logic        C0;
    logic        EN_ALU;
    logic        EN_B;
    logic [3:0]  Status;
    logic [63:0] r_obs [8];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [63:0] data;
        string       tag;
    } wr_t;
    wr_t sb_q[$];

    logic [63:0] model_regs [32];
    logic [3:0]  last_status;

    regfile_alu_datapath dut (
        .clk(clk), .rst(rst), .W(W), .DA(DA), .SA(SA), .SB(SB), .K(K),
        .K_SEL(K_SEL), .FS(FS), .C0(C0), .EN_ALU(EN_ALU), .EN_B(EN_B),
        .Status(Status),
        .r0(r_obs[0]), .r1(r_obs[1]), .r2(r_obs[2]), .r3(r_obs[3]),
        .r4(r_obs[4]), .r5(r_obs[5]), .r6(r_obs[6]), .r7(r_obs[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Reference ALU: returns {status, result}; overflow from a sign-extended sum.
    function automatic logic [67:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] fs, input logic c0);
        logic [63:0] ap, bp, r;
        logic [64:0] s;
        logic [65:0] ss;
        logic        v, c;
        ap = fs[1] ? ~a : a;
        bp = fs[0] ? ~b : b;
        v  = 1'b0;
        c  = 1'b0;
        case (fs[4:2])
            3'd0: r = ap & bp;
            3'd1: r = ap | bp;
            3'd2: begin
                s  = {1'b0, ap} + {1'b0, bp} + 65'(c0);
                ss = {{2{ap[63]}}, ap} + {{2{bp[63]}}, bp} + 66'(c0);
                r  = s[63:0];
                c  = s[64];
                v  = ss[64] != ss[63];
            end
            3'd3: r = ap ^ bp;
            3'd4: r = a << b[5:0];
            3'd5: r = a >> b[5:0];
            default: r = 64'd0;
        endcase
        return {v, c, r[63], (r == 64'd0), r};
    endfunction

    task automatic do_op(input string tag, input logic w, input logic [4:0] da,
                         input logic [4:0] sa, input logic [4:0] sb,
                         input logic [63:0] k, input logic ksel, input logic [4:0] fs,
                         input logic c0, input logic en_alu, input logic en_b);
        logic [63:0] a, b, bus;
        logic [67:0] ref_out;
        wr_t         item;
        @(negedge clk);
        W = w; DA = da; SA = sa; SB = sb; K = k; K_SEL = ksel;
        FS = fs; C0 = c0; EN_ALU = en_alu; EN_B = en_b;
        #1;
        a       = (sa == 5'd31) ? 64'd0 : model_regs[sa];
        b       = ksel ? k : ((sb == 5'd31) ? 64'd0 : model_regs[sb]);
        ref_out = alu_ref(a, b, fs, c0);
        bus     = en_alu ? ref_out[63:0] : (en_b ? b : 64'd0);
        last_status = Status;
        check({tag, "_status"}, {60'd0, Status}, {60'd0, ref_out[67:64]});
        if (w && da != 5'd31) begin
            model_regs[da] = bus;
            if (da < 5'd8) begin
                item.addr = da[2:0];
                item.data = bus;
                item.tag  = tag;
                sb_q.push_back(item);
            end
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check({item.tag, "_wb"}, r_obs[item.addr], item.data);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        W = 1'b1; DA = 5'd2; EN_B = 1'b1; EN_ALU = 1'b0; K_SEL = 1'b1;
        K = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
        for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), r_obs[i], 64'd0);
        @(negedge clk);
        rst = 1'b1;
        W = 1'b0;
    endtask

    initial begin
        rst = 1'b0; W = 1'b0; DA = '0; SA = '0; SB = '0; K = '0; K_SEL = 1'b0;
        FS = '0; C0 = 1'b0; EN_ALU = 1'b0; EN_B = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("init_r%0d", i), r_obs[i], 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Random writes, then a reset that also carries a write request
        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("rand%0d", i), 1'b1, 5'($urandom_range(0, 7)), 5'd31, 5'd0,
                  {$urandom, $urandom}, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        end
        apply_reset();
        do_op("r31_after_reset", 1'b1, 5'd6, 5'd0, 5'd31, 64'h55, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        check("r31_reads_zero", r_obs[6], 64'd0);

        // K loads through A=r31 + K
        do_op("load_r0", 1'b1, 5'd0, 5'd31, 5'd0, 64'h0000_0000_0000_FFFF, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        do_op("load_r1", 1'b1, 5'd1, 5'd31, 5'd0, 64'h0000_0000_FFFF_0000, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        do_op("load_r2", 1'b1, 5'd2, 5'd31, 5'd0, 64'h0000_FFFF_0000_0000, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        do_op("load_r3", 1'b1, 5'd3, 5'd31, 5'd0, 64'hFFFF_0000_0000_0000, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        check("const_r0", r_obs[0], 64'h0000_0000_0000_FFFF);
        check("const_r3", r_obs[3], 64'hFFFF_0000_0000_0000);

        // ~r1 + all-ones + 1
        do_op("sub_r4", 1'b1, 5'd4, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'b01010, 1'b1, 1'b1, 1'b0);
        check("const_sub_status", {60'd0, last_status}, {60'd0, 4'b0110});
        check("const_sub_r4", r_obs[4], 64'hFFFF_FFFF_0000_FFFF);

        // Bus pass-through of operand B with don't-care FS/K
        do_op("pass_r5", 1'b1, 5'd5, 5'd3, 5'd1, {$urandom, $urandom}, 1'b0,
              5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b1);
        check("const_pass_r5", r_obs[5], 64'h0000_0000_FFFF_0000);

        // Write to r31 is discarded; confirm through a pass into r5
        do_op("wr_r31", 1'b1, 5'd31, 5'd31, 5'd0, 64'h1234, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        do_op("read_r31", 1'b1, 5'd5, 5'd0, 5'd31, 64'h0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        check("const_r31_zero", r_obs[5], 64'd0);

        do_op("add_r0r0", 1'b1, 5'd6, 5'd0, 5'd0, 64'h0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0);
        check("const_add_r6", r_obs[6], 64'h0000_0000_0001_FFFE);

        do_op("load_max", 1'b1, 5'd7, 5'd31, 5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        do_op("ovf", 1'b1, 5'd7, 5'd7, 5'd0, 64'h1, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        check("const_ovf_status", {60'd0, last_status}, {60'd0, 4'b1010});

        // Same-cycle read of the register being written sees the old value
        do_op("rmw_a", 1'b1, 5'd6, 5'd6, 5'd0, 64'h1, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        do_op("rmw_b", 1'b1, 5'd6, 5'd6, 5'd0, 64'h1, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);

        // Shifts, logic ops, and both bus enables high
        do_op("lsl4", 1'b1, 5'd4, 5'd0, 5'd0, 64'd4, 1'b1, 5'b10000, 1'b0, 1'b1, 1'b0);
        check("const_lsl", r_obs[4], 64'h0000_0000_000F_FFF0);
        do_op("lsr64", 1'b1, 5'd5, 5'd0, 5'd0, 64'd64, 1'b1, 5'b10100, 1'b0, 1'b1, 1'b0);
        check("const_lsr", r_obs[5], 64'h0000_0000_0000_FFFF);
        do_op("and0", 1'b1, 5'd5, 5'd0, 5'd0, 64'd0, 1'b1, 5'b00000, 1'b0, 1'b1, 1'b0);
        check("const_and_z", {60'd0, last_status}, {60'd0, 4'b0001});
        do_op("or_inv", 1'b1, 5'd4, 5'd1, 5'd2, 64'd0, 1'b0, 5'b00110, 1'b0, 1'b1, 1'b0);
        do_op("xor", 1'b1, 5'd3, 5'd0, 5'd1, 64'd0, 1'b0, 5'b01100, 1'b0, 1'b1, 1'b0);
        do_op("op_110", 1'b1, 5'd2, 5'd0, 5'd1, 64'd0, 1'b0, 5'b11000, 1'b0, 1'b1, 1'b0);
        do_op("both_en", 1'b1, 5'd1, 5'd0, 5'd0, 64'hAAAA, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b1);
        check("const_both_en", r_obs[1], 64'h0000_0000_0001_AAA9);
        do_op("no_en", 1'b1, 5'd0, 5'd0, 5'd0, 64'hAAAA, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b0);
        do_op("no_write", 1'b0, 5'd1, 5'd0, 5'd0, 64'h5555, 1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
        check("hold_r1", r_obs[1], 64'h0000_0000_0001_AAA9);

        // Reset in the middle of the sequence discards that cycle's write
        apply_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
